// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   - R_*     : result encodings driven on R ({A>B, A==B, A<B}).
//   - ST_*    : FSM state encodings (IDLE / RUN / DONE).
package comparator_pkg;

  localparam logic [2:0] R_GT   = 3'b100;
  localparam logic [2:0] R_EQ   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;
  localparam logic [2:0] R_NONE = 3'b000;

  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/slice_compare.sv
// Combinational unsigned compare of one SLICE-bit slice.
// Ports:
//   a, b : slice operands
//   gt   : a > b
//   lt   : a < b   (neither set means the slices are equal)
module slice_compare #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands SLICE bits per clock
// from the MSB down and stops at the first differing slice.
// Ports:
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   start       : request, accepted only in IDLE or DONE
//   signed_mode : 1 = two's-complement, 0 = unsigned; captured with start
//   A, B        : operands; captured with start
//   busy        : high while the compare is running
//   done        : one-cycle pulse when R has just been updated
//   R           : {A>B, A==B, A<B}; holds until the next compare completes
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [2:0]       R
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         r_q, r_d;

  logic [SLICE-1:0]   a_sl, b_sl;
  logic               sl_gt, sl_lt;

  // Slice multiplexer: slice idx sits at bits [WIDTH-1-idx*SLICE -: SLICE].
  assign a_sl = a_q[WIDTH-1 - int'(idx_q)*SLICE -: SLICE];
  assign b_sl = b_q[WIDTH-1 - int'(idx_q)*SLICE -: SLICE];

  slice_compare #(.SLICE(SLICE)) u_slice_compare (
    .a  (a_sl),
    .b  (b_sl),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          // Flipping both sign bits at capture turns a two's-complement
          // compare into an unsigned one; only slice 0 is affected.
          a_d     = A ^ (MSB_MASK & {WIDTH{signed_mode}});
          b_d     = B ^ (MSB_MASK & {WIDTH{signed_mode}});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sl_gt || sl_lt) begin
          r_d     = sl_gt ? R_GT : R_LT;
          state_d = ST_DONE;
        end else if (idx_q == IDX_LAST) begin
          r_d     = R_EQ;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the operand registers are ordinary flops, so they are
  // cleared by reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= R_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign R    = r_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (16/4 and 8/8 builds).
module tb_serial_magnitude_comparator;

  localparam logic [2:0] E_GT = 3'b100;
  localparam logic [2:0] E_EQ = 3'b010;
  localparam logic [2:0] E_LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_mode;
  logic [15:0] A, B;
  logic        busy, done;
  logic [2:0]  R;

  logic        start8, signed_mode8;
  logic [7:0]  A8, B8;
  logic        busy8, done8;
  logic [2:0]  R8;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  last_r = 3'b000;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(16), .SLICE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .R           (R)
  );

  serial_magnitude_comparator #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .signed_mode (signed_mode8),
    .A           (A8),
    .B           (B8),
    .busy        (busy8),
    .done        (done8),
    .R           (R8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result from plain integer comparison; latency is the position
  // of the first differing nibble (counted from the MSB) plus one.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic sm, output logic [2:0] r, output int lat);
    logic [15:0] diff;
    logic        a_gt;
    diff = a ^ b;
    if (a == b) begin
      r   = E_EQ;
      lat = 4;
    end else begin
      a_gt = sm ? ($signed(a) > $signed(b)) : (a > b);
      r    = a_gt ? E_GT : E_LT;
      lat  = 1;
      while (diff[15:12] == 4'h0) begin
        diff = diff << 4;
        lat++;
      end
    end
  endfunction

  // Runs one compare on the 16/4 DUT. With b2b set, the call is made in a
  // DONE cycle and start is driven immediately.
  task automatic do_compare(input logic [15:0] a, input logic [15:0] b,
                            input logic sm, input string tag, input bit b2b);
    logic [2:0] er;
    int         el, lat, busy_cnt;
    bit         seen;
    model(a, b, sm, er, el);
    if (!b2b) begin
      @(negedge clk);
      check({tag, "_pre_done"}, done, 0);
    end
    A = a; B = b; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); signed_mode = ~sm;
    seen = 0; lat = 0; busy_cnt = 0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, "_r_hold"}, R, last_r);
      if (done) begin
        seen = 1;
        lat  = c;
        check({tag, "_busy_at_done"}, busy, 0);
      end else if (busy) begin
        busy_cnt++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat, el);
    check({tag, "_busy_cycles"}, busy_cnt, el);
    check({tag, "_R"}, R, er);
    last_r = er;
  endtask

  initial begin
    int          pulses, lat;
    logic [15:0] ra, rb;
    logic        rsm;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
    start8 = 1'b0; signed_mode8 = 1'b0; A8 = '0; B8 = '0;

    // 1. reset held for two edges, then released with start low
    @(posedge clk); @(posedge clk); #1;
    check("rst_R", R, 3'b000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("post_rst_R", R, 3'b000);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    // 2-4. directed compares
    do_compare(16'h1234, 16'h1234, 1'b0, "equal", 0);
    do_compare(16'hA000, 16'h9FFF, 1'b0, "early_gt", 0);
    do_compare(16'h8000, 16'h0001, 1'b1, "signed_lt", 0);
    do_compare(16'h8000, 16'h0001, 1'b0, "unsigned_gt", 0);

    // 5. second start during RUN is ignored; exactly one done pulse
    @(negedge clk);
    A = 16'h12F0; B = 16'h1300; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_busy", busy, 1);
    A = 16'hFFFF; B = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) lat = c + 1;
      end
    end
    check("ign_pulses", pulses, 1);
    check("ign_latency", lat, 2);
    check("ign_R", R, E_LT);
    last_r = E_LT;

    // 6. reset during RUN aborts without a done pulse
    @(negedge clk);
    A = 16'h5A5A; B = 16'h5A5A; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_off", busy, 0);
    check("abort_done", done, 0);
    check("abort_R", R, 3'b000);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    last_r = 3'b000;
    do_compare(16'h0F00, 16'h0E00, 1'b0, "after_abort", 0);

    // randomized compares; every third one starts in the DONE cycle
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rsm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: rb = 16'($urandom);
      endcase
      do_compare(ra, rb, rsm, $sformatf("rnd%0d", i), (i % 3 == 2));
    end

    // 7. single-slice build: one-cycle compare
    @(negedge clk);
    A8 = 8'd7; B8 = 8'd9; signed_mode8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    check("w8_busy", busy8, 1);
    @(negedge clk);
    check("w8_done", done8, 1);
    check("w8_R", R8, E_LT);
    check("w8_busy_off", busy8, 0);

    A8 = 8'h80; B8 = 8'h7F; signed_mode8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    check("w8_signed_done", done8, 1);
    check("w8_signed_R", R8, E_LT);

    A8 = 8'h80; B8 = 8'h7F; signed_mode8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    check("w8_unsigned_done", done8, 1);
    check("w8_unsigned_R", R8, E_GT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
